trng_collector: RTL

//  Parametrised multi-bank entropy collector for the TRNG path. Accepts Bpc-bit raw samples from

---
 rtl/trng_collector_pkg.sv | 21 ++
 rtl/trng_fifo.sv | 70 +++++++
 rtl/trng_collector.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trng_collector_pkg.sv
// trng_collector_pkg
//   Shared helpers for the entropy collector: constant-width functions used
//   to size pointers, counters and the FIFO level port.
//   No ports (package).
package trng_collector_pkg;

  // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Index width that never collapses to zero bits (a single bank still
  // needs a 1-bit pointer to keep the vectors legal).
  function automatic int idx_width(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

endpackage

// File: rtl/trng_fifo.sv
// trng_fifo
//   Synchronous first-word-fall-through FIFO for packed entropy words.
//   The head word is visible on rd_data whenever empty==0.
// Ports
//   clock    in   system clock
//   reset    in   synchronous, active-low reset
//   push     in   write wr_data (ignored when full unless popping same cycle)
//   wr_data  in   WIDTH-bit word to store
//   pop      in   discard head word (ignored when empty)
//   rd_data  out  head word (undefined contents when empty)
//   full     out  DEPTH words stored
//   empty    out  no words stored
//   level    out  number of words stored
module trng_fifo
  import trng_collector_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = idx_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == FULL_LEVEL);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign level   = level_reg;
  assign rd_data = mem[rd_ptr_reg];

  // Storage array carries no reset so it maps onto plain memory.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/trng_collector.sv
// trng_collector
//   Multi-bank entropy collector: captures raw samples per bank, grants one
//   bank per cycle round-robin, runs a repetition-count health test per bank,
//   optionally XOR-folds sample pairs, packs samples MSB-first into Dbw-bit
//   words and buffers them in a FWFT FIFO with ready/valid output.
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-low reset
//   smp_in       in   bank i sample on [i*Bpc +: Bpc]
//   smp_valid    in   per-bank capture pulse
//   bank_en      in   per-bank enable
//   decim_en     in   1: XOR-fold pairs of accepted samples
//   clear_err    in   pulse: clears health_fail, overrun and RCT counters
//   data_ready   in   consumer ready
//   data_out     out  FIFO head word, 0 when empty
//   data_valid   out  FIFO not empty
//   fifo_level   out  words stored in the FIFO
//   health_fail  out  sticky repetition-count failure per bank
//   overrun      out  sticky sample-dropped flag per bank
module trng_collector
  import trng_collector_pkg::*;
#(
  parameter int BANK_UNITS = 4,
  parameter int Bpc        = 4,
  parameter int Dbw        = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_CUTOFF = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [BANK_UNITS*Bpc-1:0] smp_in,
  input  logic [BANK_UNITS-1:0]     smp_valid,
  input  logic [BANK_UNITS-1:0]     bank_en,
  input  logic                      decim_en,
  input  logic                      clear_err,
  input  logic                      data_ready,
  output logic [Dbw-1:0]            data_out,
  output logic                      data_valid,
  output logic [clog2(FIFO_DEPTH):0] fifo_level,
  output logic [BANK_UNITS-1:0]     health_fail,
  output logic [BANK_UNITS-1:0]     overrun
);

  localparam int WPS = Dbw / Bpc;
  localparam int PW  = idx_width(BANK_UNITS);
  localparam int CW  = clog2(WPS + 1);
  localparam int RW  = clog2(RCT_CUTOFF + 1);

  // Per-bank state gathered into vectors/arrays for the shared grant path.
  logic [Bpc-1:0]        hold_arr [BANK_UNITS];
  logic [Bpc-1:0]        last_arr [BANK_UNITS];
  logic [RW-1:0]         rct_arr  [BANK_UNITS];
  logic [BANK_UNITS-1:0] pending_vec;
  logic [BANK_UNITS-1:0] health_vec;
  logic [BANK_UNITS-1:0] overrun_vec;

  logic [PW-1:0]  ptr_reg;
  logic           grant_allowed;
  logic           grant_valid;
  logic [PW-1:0]  grant_idx;
  int             cand;

  logic [Bpc-1:0] grant_smp;
  logic [RW-1:0]  grant_rct;
  logic [RW-1:0]  rct_upd;
  logic           trip;
  logic           accept;

  logic           fold_valid_reg;
  logic [Bpc-1:0] fold_reg;
  logic           pack_in_valid;
  logic [Bpc-1:0] pack_in_data;
  logic [Dbw-1:0] pack_word_reg;
  logic [CW-1:0]  pack_cnt_reg;
  logic           pack_full;

  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [Dbw-1:0] fifo_rd_data;

  // ---------------------------------------------------------------- banks
  for (genvar gi = 0; gi < BANK_UNITS; gi++) begin : g_bank
    logic           granted;
    logic           load;
    logic [Bpc-1:0] hold_reg;
    logic           pending_reg;
    logic           overrun_reg;
    logic [Bpc-1:0] last_reg;
    logic [RW-1:0]  rct_reg;
    logic           health_reg;

    assign granted = grant_valid && (grant_idx == PW'(gi));
    assign load    = smp_valid[gi] && bank_en[gi];

    assign hold_arr[gi]    = hold_reg;
    assign last_arr[gi]    = last_reg;
    assign rct_arr[gi]     = rct_reg;
    assign pending_vec[gi] = pending_reg;
    assign health_vec[gi]  = health_reg;
    assign overrun_vec[gi] = overrun_reg;

    always_ff @(posedge clock) begin
      if (!reset) begin
        hold_reg    <= '0;
        pending_reg <= 1'b0;
        overrun_reg <= 1'b0;
        last_reg    <= '0;
        rct_reg     <= '0;
        health_reg  <= 1'b0;
      end else begin
        // A grant in the same cycle empties the holding register, so the
        // new sample can take its place without loss.
        if (load && (!pending_reg || granted)) begin
          hold_reg    <= smp_in[gi*Bpc +: Bpc];
          pending_reg <= 1'b1;
        end else if (granted) begin
          pending_reg <= 1'b0;
        end

        if (clear_err) begin
          overrun_reg <= 1'b0;
        end else if (load && pending_reg && !granted) begin
          overrun_reg <= 1'b1;
        end

        if (granted) last_reg <= grant_smp;

        // Clear has priority over a trip landing in the same cycle.
        if (clear_err) begin
          rct_reg    <= '0;
          health_reg <= 1'b0;
        end else if (granted) begin
          rct_reg <= rct_upd;
          if (trip) health_reg <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------- arbiter
  // Stall grants only when a full word is stuck in the packer.
  assign grant_allowed = !pack_full || fifo_push;

  // Scan offsets from highest to lowest so the nearest pending bank at or
  // after the pointer is the last assignment and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (grant_allowed) begin
      for (int k = BANK_UNITS - 1; k >= 0; k--) begin
        cand = int'(ptr_reg) + k;
        if (cand >= BANK_UNITS) cand = cand - BANK_UNITS;
        if (pending_vec[cand[PW-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = cand[PW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_reg <= '0;
    end else if (grant_valid) begin
      ptr_reg <= (grant_idx == PW'(BANK_UNITS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // --------------------------------------------------------------- health
  always_comb begin
    grant_smp = hold_arr[grant_idx];
    grant_rct = rct_arr[grant_idx];
    if (grant_smp == last_arr[grant_idx]) begin
      rct_upd = (grant_rct == RW'(RCT_CUTOFF)) ? grant_rct : grant_rct + 1'b1;
    end else begin
      rct_upd = RW'(1);
    end
    trip   = grant_valid && (rct_upd == RW'(RCT_CUTOFF));
    // Samples of a failed bank, including the one that trips it, are
    // consumed from the holding register but never reach the packer.
    accept = grant_valid && !health_vec[grant_idx] && !trip;
  end

  // ----------------------------------------------------------- decimation
  // The decim_en decision is taken only on the first sample of a pair, so
  // toggling it mid-pair still completes the pair in progress.
  always_comb begin
    pack_in_valid = 1'b0;
    pack_in_data  = grant_smp;
    if (accept) begin
      if (fold_valid_reg) begin
        pack_in_valid = 1'b1;
        pack_in_data  = fold_reg ^ grant_smp;
      end else if (!decim_en) begin
        pack_in_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fold_valid_reg <= 1'b0;
      fold_reg       <= '0;
    end else if (accept) begin
      if (fold_valid_reg) begin
        fold_valid_reg <= 1'b0;
      end else if (decim_en) begin
        fold_valid_reg <= 1'b1;
        fold_reg       <= grant_smp;
      end
    end
  end

  // --------------------------------------------------------------- packer
  assign pack_full = (pack_cnt_reg == CW'(WPS));
  assign fifo_pop  = data_valid && data_ready;
  assign fifo_push = pack_full && (!fifo_full || fifo_pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      pack_word_reg <= '0;
      pack_cnt_reg  <= '0;
    end else begin
      // Older samples shift toward the MSB; a full word is overwritten
      // entirely by the next WPS samples, so no explicit clear on push.
      if (pack_in_valid) pack_word_reg <= {pack_word_reg[Dbw-Bpc-1:0], pack_in_data};
      if (fifo_push) begin
        pack_cnt_reg <= pack_in_valid ? CW'(1) : '0;
      end else if (pack_in_valid) begin
        pack_cnt_reg <= pack_cnt_reg + 1'b1;
      end
    end
  end

  // ----------------------------------------------------------------- fifo
  trng_fifo #(
    .WIDTH (Dbw),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (pack_word_reg),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign data_valid  = !fifo_empty;
  assign data_out    = fifo_empty ? '0 : fifo_rd_data;
  assign health_fail = health_vec;
  assign overrun     = overrun_vec;

endmodule
